// File: rtl/keypad_entry.sv
// Credential-capture front end for the ATM core: decimal account/PIN entry,
// authentication hand-off, failed-attempt lockout and inactivity timeout.
module keypad_entry #(
  parameter int ACC_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCK_CYCLES    = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        auth_valid,
  input  logic        auth_ok,
  output logic [11:0] acc_number,
  output logic [3:0]  pin,
  output logic        cred_valid,
  output logic        exit,
  output logic        session_active,
  output logic        locked,
  output logic        entry_error,
  output logic [1:0]  fail_count
);
  localparam int CNT_W = $clog2(ACC_DIGITS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;
  localparam logic [1:0] FAIL_MAX   = 2'(MAX_ATTEMPTS);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(ACC_DIGITS);
  localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LCK_W-1:0] LCK_LOAD   = LCK_W'(LOCK_CYCLES);

  typedef enum logic [2:0] {IDLE, ACC_ENTRY, PIN_ENTRY, SUBMIT, SESSION, LOCKED} state_t;
  state_t state, state_next;

  logic [13:0]      acc_acc, acc_acc_next;
  logic [CNT_W-1:0] acc_cnt, acc_cnt_next;
  logic [3:0]       pin_reg, pin_reg_next;
  logic             pin_set, pin_set_next;
  logic [11:0]      acc_number_next;
  logic [3:0]       pin_next;
  logic             cred_valid_next, exit_next, session_next, locked_next, entry_error_next;
  logic [1:0]       fail_next, fail_inc;
  logic [TMO_W-1:0] tmo_cnt, tmo_next;
  logic [LCK_W-1:0] lock_cnt, lock_next;
  logic [16:0]      acc_prod;
  logic             is_digit, tmo_active, tmo_expire;

  assign is_digit   = key_code <= 4'd9;
  assign acc_prod   = {3'b000, acc_acc} * 17'd10 + {13'd0, key_code};
  assign tmo_active = (state == ACC_ENTRY) || (state == PIN_ENTRY) ||
                      (state == SUBMIT) || (state == SESSION);
  // A key arriving on the expiry cycle wins: the counter reloads instead.
  assign tmo_expire = tmo_active && (tmo_cnt == '0) && !key_valid;
  assign fail_inc   = (fail_count >= FAIL_MAX) ? FAIL_MAX : fail_count + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next       = state;
    acc_acc_next     = acc_acc;
    acc_cnt_next     = acc_cnt;
    pin_reg_next     = pin_reg;
    pin_set_next     = pin_set;
    acc_number_next  = acc_number;
    pin_next         = pin;
    cred_valid_next  = 1'b0;
    exit_next        = 1'b0;
    session_next     = session_active;
    locked_next      = locked;
    entry_error_next = 1'b0;
    fail_next        = fail_count;
    lock_next        = lock_cnt;

    if (tmo_expire) begin
      state_next      = IDLE;
      acc_acc_next    = '0;
      acc_cnt_next    = '0;
      pin_reg_next    = '0;
      pin_set_next    = 1'b0;
      acc_number_next = '0;
      pin_next        = '0;
      session_next    = 1'b0;
      exit_next       = (state == SESSION) || (state == SUBMIT);
    end else begin
      unique case (state)
        IDLE: if (key_valid && is_digit) begin
          acc_acc_next = {10'd0, key_code};
          acc_cnt_next = CNT_W'(1);
          state_next   = ACC_ENTRY;
        end
        ACC_ENTRY: if (key_valid) begin
          if (is_digit) begin
            if (acc_cnt == CNT_MAX || acc_prod > 17'd4095) begin
              entry_error_next = 1'b1;
              acc_acc_next     = '0;
              acc_cnt_next     = '0;
            end else begin
              acc_acc_next = acc_prod[13:0];
              acc_cnt_next = acc_cnt + CNT_W'(1);
            end
          end else if (key_code == KEY_CLEAR) begin
            acc_acc_next = '0;
            acc_cnt_next = '0;
          end else if (key_code == KEY_ENTER && acc_cnt != '0) begin
            pin_reg_next = '0;
            pin_set_next = 1'b0;
            state_next   = PIN_ENTRY;
          end else if (key_code == KEY_CANCEL) begin
            state_next = IDLE;
          end
        end
        PIN_ENTRY: if (key_valid) begin
          if (is_digit) begin
            pin_reg_next = key_code;
            pin_set_next = 1'b1;
          end else if (key_code == KEY_CLEAR) begin
            pin_reg_next = '0;
            pin_set_next = 1'b0;
          end else if (key_code == KEY_ENTER) begin
            if (!pin_set) entry_error_next = 1'b1;
            else begin
              acc_number_next = acc_acc[11:0];
              pin_next        = pin_reg;
              cred_valid_next = 1'b1;
              state_next      = SUBMIT;
            end
          end else if (key_code == KEY_CANCEL) begin
            state_next = IDLE;
          end
        end
        SUBMIT: if (auth_valid) begin
          if (auth_ok) begin
            fail_next    = '0;
            session_next = 1'b1;
            state_next   = SESSION;
          end else begin
            fail_next       = fail_inc;
            acc_number_next = '0;
            pin_next        = '0;
            if (fail_inc >= FAIL_MAX) begin
              locked_next = 1'b1;
              lock_next   = LCK_LOAD;
              state_next  = LOCKED;
            end else begin
              state_next = IDLE;
            end
          end
        end
        SESSION: if (key_valid && key_code == KEY_CANCEL) begin
          exit_next       = 1'b1;
          session_next    = 1'b0;
          acc_number_next = '0;
          pin_next        = '0;
          state_next      = IDLE;
        end
        LOCKED: begin
          if (lock_cnt == '0) begin
            locked_next = 1'b0;
            fail_next   = '0;
            state_next  = IDLE;
          end else begin
            lock_next = lock_cnt - LCK_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (key_valid || state_next != state || !tmo_active) tmo_next = TMO_RELOAD;
    else                                                 tmo_next = tmo_cnt - TMO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_acc        <= '0;
      acc_cnt        <= '0;
      pin_reg        <= '0;
      pin_set        <= 1'b0;
      acc_number     <= '0;
      pin            <= '0;
      cred_valid     <= 1'b0;
      exit           <= 1'b0;
      session_active <= 1'b0;
      locked         <= 1'b0;
      entry_error    <= 1'b0;
      fail_count     <= '0;
      tmo_cnt        <= TMO_RELOAD;
      lock_cnt       <= '0;
    end else begin
      acc_acc        <= acc_acc_next;
      acc_cnt        <= acc_cnt_next;
      pin_reg        <= pin_reg_next;
      pin_set        <= pin_set_next;
      acc_number     <= acc_number_next;
      pin            <= pin_next;
      cred_valid     <= cred_valid_next;
      exit           <= exit_next;
      session_active <= session_next;
      locked         <= locked_next;
      entry_error    <= entry_error_next;
      fail_count     <= fail_next;
      tmo_cnt        <= tmo_next;
      lock_cnt       <= lock_next;
    end
  end
endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with short timeout/lock parameters.
module tb_keypad_entry;
  localparam int TMO  = 40;
  localparam int LOCK = 60;
  localparam logic [3:0] CLR = 4'hA, ENT = 4'hB, CAN = 4'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = '0;
  logic        auth_valid = 1'b0;
  logic        auth_ok = 1'b0;
  logic [11:0] acc_number;
  logic [3:0]  pin;
  logic        cred_valid, exit, session_active, locked, entry_error;
  logic [1:0]  fail_count;

  int n_cmp = 0;
  int n_bad = 0;

  keypad_entry #(.ACC_DIGITS(4), .TIMEOUT_CYCLES(TMO), .MAX_ATTEMPTS(3), .LOCK_CYCLES(LOCK)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .auth_valid(auth_valid), .auth_ok(auth_ok), .acc_number(acc_number), .pin(pin),
    .cred_valid(cred_valid), .exit(exit), .session_active(session_active),
    .locked(locked), .entry_error(entry_error), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic press(input logic [3:0] c);
    @(negedge clk); key_valid = 1'b1; key_code = c;
    @(posedge clk); #1; key_valid = 1'b0;
  endtask

  task automatic auth(input logic ok, input logic with_key, input logic [3:0] c);
    @(negedge clk); auth_valid = 1'b1; auth_ok = ok; key_valid = with_key; key_code = c;
    @(posedge clk); #1; auth_valid = 1'b0; key_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic saw;
    // Reset
    repeat (2) @(negedge clk);
    chk("rst_acc", acc_number, 0);
    chk("rst_pin", pin, 0);
    chk("rst_flags", {cred_valid, exit, session_active, locked, entry_error}, 0);
    chk("rst_fail", fail_count, 0);
    rst_n = 1'b1;

    // 2749 / PIN 0, accepted
    press(2); press(7); press(4); press(9); press(ENT); press(0); press(ENT);
    chk("t1_cred", cred_valid, 1);
    chk("t1_acc", acc_number, 2749);
    chk("t1_pin", pin, 0);
    tick();
    chk("t1_cred_1cyc", cred_valid, 0);
    auth(1'b1, 1'b0, 4'h0);
    chk("t1_sess", session_active, 1);
    chk("t1_fail", fail_count, 0);
    press(CAN);
    chk("t1_exit", exit, 1);
    chk("t1_sess_off", session_active, 0);
    chk("t1_acc_clr", acc_number, 0);
    tick();
    chk("t1_exit_1cyc", exit, 0);

    // Overflow on 9999, then 2175 / PIN 1, rejected
    press(9); press(9); press(9);
    chk("t2_no_err", entry_error, 0);
    press(9);
    chk("t2_err", entry_error, 1);
    tick();
    chk("t2_err_1cyc", entry_error, 0);
    press(2); press(1); press(7); press(5); press(ENT); press(1); press(ENT);
    chk("t2_acc", acc_number, 2175);
    chk("t2_pin", pin, 1);
    auth(1'b0, 1'b0, 4'h0);
    chk("t2_fail1", fail_count, 1);
    chk("t2_acc_clr", acc_number, 0);

    // Two more failures -> lockout
    press(3); press(ENT); press(4); press(ENT);
    auth(1'b0, 1'b0, 4'h0);
    chk("t3_fail2", fail_count, 2);
    chk("t3_not_locked", locked, 0);
    press(5); press(ENT); press(ENT);
    chk("t3_pin_missing", entry_error, 1);
    press(6); press(ENT);
    chk("t3_cred", cred_valid, 1);
    auth(1'b0, 1'b0, 4'h0);
    chk("t3_fail3", fail_count, 3);
    chk("t3_locked", locked, 1);
    n = 0; saw = 1'b0;
    while (locked === 1'b1 && n < 200) begin
      @(negedge clk); key_valid = n[0]; key_code = 4'(n % 16);
      @(posedge clk); #1; key_valid = 1'b0; n++;
      if (cred_valid !== 1'b0 || entry_error !== 1'b0) saw = 1'b1;
    end
    chk("t3_lock_len", n, LOCK + 1);
    chk("t3_keys_ignored", saw, 0);
    chk("t3_fail_reset", fail_count, 0);

    // CLEAR mid-entry, 2647 / PIN 5, auth coincident with a CANCEL key
    press(2); press(4); press(CLR);
    press(2); press(6); press(4); press(7); press(ENT); press(5); press(ENT);
    chk("t5_acc", acc_number, 2647);
    chk("t5_pin", pin, 5);
    auth(1'b1, 1'b1, CAN);
    chk("t5_sess", session_active, 1);
    chk("t5_no_exit", exit, 0);
    chk("t5_acc_hold", acc_number, 2647);

    // Session inactivity timeout
    repeat (TMO - 1) tick();
    chk("t4_sess_before_tmo", session_active, 1);
    tick();
    chk("t4_tmo_exit", exit, 1);
    chk("t4_tmo_sess", session_active, 0);
    chk("t4_tmo_acc", acc_number, 0);
    tick();
    chk("t4_tmo_exit_1cyc", exit, 0);

    // Key in session reloads the timeout
    press(1); press(ENT); press(1); press(ENT);
    auth(1'b1, 1'b0, 4'h0);
    repeat (30) tick();
    press(5);
    repeat (TMO - 1) tick();
    chk("t4_reload_sess", session_active, 1);
    tick();
    chk("t4_reload_exit", exit, 1);

    // Entry timeout: no exit, partial account discarded
    press(3);
    repeat (TMO - 1) tick();
    tick();
    chk("t6_acc_tmo_no_exit", exit, 0);
    press(4); press(ENT); press(7); press(ENT);
    chk("t6_acc_fresh", acc_number, 4);
    chk("t6_pin", pin, 7);

    // Fifth digit rejected
    auth(1'b0, 1'b0, 4'h0);
    press(1); press(2); press(3); press(4);
    chk("t6_4dig_ok", entry_error, 0);
    press(5);
    chk("t6_5th_err", entry_error, 1);

    // Reset mid ACC_ENTRY
    press(1); press(2);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("t7_rst_err", entry_error, 0);
    @(negedge clk); rst_n = 1'b1;
    chk("t7_rst_fail", fail_count, 0);
    press(ENT); press(5); press(ENT); press(3); press(ENT);
    chk("t7_acc", acc_number, 5);
    chk("t7_pin", pin, 3);

    // Reset mid SESSION
    auth(1'b1, 1'b0, 4'h0);
    chk("t7_sess", session_active, 1);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("t7_rst_sess", session_active, 0);
    chk("t7_rst_acc", acc_number, 0);
    chk("t7_rst_exit", exit, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("t7_no_exit", exit, 0);
    press(CAN);
    chk("t7_idle_cancel", exit, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
